// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared widths, op encodings and overflow helper for the ALU
//            post-accumulator stage.
// Revision : 1.0
// ============================================================================
package alu_pkg;

   localparam int W_DEF     = 48;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      OP_PASS      = 2'b00,
      OP_ACC       = 2'b01,
      OP_ACC_FLUSH = 2'b10,
      OP_CLEAR     = 2'b11
   } op_e;

   // Operands share a sign but the sum's sign differs.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage
`default_nettype wire

// File: rtl/out_reg_slice.sv
`default_nettype none
// ============================================================================
// Module   : out_reg_slice
// Brief    : Single-entry valid/ready output register holding the emitted
//            sum, element count, overflow flag and pattern-hit flag.
// Revision : 1.0
// ============================================================================
module out_reg_slice #(
   parameter int W     = 48,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [W-1:0]     sum_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic             ovf_i,
   input  logic             hit_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [W-1:0]     sum_o,
   output logic [CNT_W-1:0] count_o,
   output logic             ovf_o,
   output logic             hit_o
);

   logic             valid_q;
   logic [W-1:0]     sum_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;
   logic             hit_q;

   // Upstream only loads when the slot is free or draining, so a load always wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         sum_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         hit_q   <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         sum_q   <= sum_i;
         count_q <= count_i;
         ovf_q   <= ovf_i;
         hit_q   <= hit_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign sum_o   = sum_q;
   assign count_o = count_q;
   assign ovf_o   = ovf_q;
   assign hit_o   = hit_q;

endmodule
`default_nettype wire

// File: rtl/alu_post_accum.sv
`default_nettype none
// ============================================================================
// Module   : alu_post_accum
// Brief    : ALU downstream stage: pass-through or signed accumulate with
//            flush, count, sticky overflow and pattern match.
// Revision : 1.0
// ============================================================================
module alu_post_accum
   import alu_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_p,
   input  logic [1:0]       in_op,
   input  logic [W-1:0]     pattern,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             pat_hit
);

   logic [W-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   op_e              op;
   logic [W-1:0]     add_sum;
   logic             add_ov;
   logic [CNT_W-1:0] cnt_inc;

   logic             ld;
   logic [W-1:0]     ld_sum;
   logic [CNT_W-1:0] ld_cnt;
   logic             ld_ovf;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign op       = op_e'(in_op);
   assign add_sum  = acc_q + in_p;
   assign add_ov   = add_ovf(acc_q[W-1], in_p[W-1], add_sum[W-1]);
   assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      ld     = 1'b0;
      ld_sum = in_p;
      ld_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
      ld_ovf = 1'b0;
      if (accept) begin
         case (op)
            OP_PASS: begin
               ld = 1'b1;
            end
            OP_ACC: begin
               acc_d = add_sum;
               cnt_d = cnt_inc;
               ovf_d = ovf_q | add_ov;
            end
            OP_ACC_FLUSH: begin
               ld     = 1'b1;
               ld_sum = add_sum;
               ld_cnt = cnt_inc;
               ld_ovf = ovf_q | add_ov;
               acc_d  = '0;
               cnt_d  = '0;
               ovf_d  = 1'b0;
            end
            OP_CLEAR: begin
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   out_reg_slice #(
      .W     (W),
      .CNT_W (CNT_W)
   ) u_out (
      .clk     (clk),
      .rst     (rst),
      .load_i  (ld),
      .sum_i   (ld_sum),
      .count_i (ld_cnt),
      .ovf_i   (ld_ovf),
      .hit_i   (ld_sum == pattern),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .sum_o   (out_sum),
      .count_o (out_count),
      .ovf_o   (out_ovf),
      .hit_o   (pat_hit)
   );

endmodule
`default_nettype wire

// File: tb/tb_alu_post_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_post_accum
// Brief    : Self-checking bench: vector table, corner sequences and a
//            randomized run against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_alu_post_accum;

   localparam logic [1:0] C_PASS  = 2'b00;
   localparam logic [1:0] C_ACC   = 2'b01;
   localparam logic [1:0] C_FLUSH = 2'b10;
   localparam logic [1:0] C_CLEAR = 2'b11;
   localparam longint C_MAX = 64'sd140737488355327;
   localparam longint C_MIN = -64'sd140737488355328;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [47:0] in_p = '0;
   logic [1:0]  in_op = '0;
   logic [47:0] pattern = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [47:0] out_sum;
   logic [7:0]  out_count;
   logic        out_ovf;
   logic        pat_hit;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   alu_post_accum dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_p      (in_p),
      .in_op     (in_op),
      .pattern   (pattern),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf),
      .pat_hit   (pat_hit)
   );

   typedef struct {
      logic [1:0]  op;
      logic [47:0] p;
      logic [47:0] pat;
      logic        ev;
      logic [47:0] es;
      logic [7:0]  ec;
      logic        eo;
      logic        eh;
   } vec_t;

   typedef struct {
      logic [47:0] s;
      logic [7:0]  c;
      logic        o;
      logic        h;
   } exp_t;

   vec_t vt[$];
   exp_t q[$];

   longint m_acc;
   int     m_cnt;
   bit     m_ovf;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: true integer sum, overflow when it leaves the 48-bit signed range.
   task automatic model_add(input logic [47:0] p, output logic [47:0] s,
                            output bit o, output int c);
      longint b;
      longint t;
      b = $signed(p);
      t = m_acc + b;
      o = (t > C_MAX) || (t < C_MIN);
      s = t[47:0];
      c = (m_cnt >= 255) ? 255 : m_cnt + 1;
   endtask

   task automatic model_op(input logic [1:0] op, input logic [47:0] p, input logic [47:0] pat);
      logic [47:0] s;
      bit o;
      int c;
      exp_t e;
      model_add(p, s, o, c);
      case (op)
         C_PASS: begin
            e.s = p; e.c = 8'd1; e.o = 1'b0; e.h = (p == pat);
            q.push_back(e);
         end
         C_ACC: begin
            m_acc = $signed(s); m_cnt = c; m_ovf = m_ovf | o;
         end
         C_FLUSH: begin
            e.s = s; e.c = 8'(c); e.o = m_ovf | o; e.h = (s == pat);
            q.push_back(e);
            m_acc = 0; m_cnt = 0; m_ovf = 0;
         end
         default: begin
            m_acc = 0; m_cnt = 0; m_ovf = 0;
         end
      endcase
   endtask

   function automatic logic [47:0] rnd_val();
      logic [47:0] v;
      case ($urandom_range(0, 3))
         0: v = 48'($urandom_range(0, 20));
         1: v = 48'(0) - 48'($urandom_range(1, 20));
         2: v = {$urandom, $urandom};
         default: v = $urandom_range(0, 1) ? 48'h7FFF_FFFF_FFF0 + 48'($urandom_range(0, 15))
                                           : 48'h8000_0000_0000 + 48'($urandom_range(0, 15));
      endcase
      return v;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] r_op;
      bit exp_rdy;
      exp_t e;

      #2;
      chk("rst_valid", out_valid, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_count", out_count, 0);
      chk("rst_flags", {out_ovf, pat_hit}, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("idle_valid", out_valid, 0);
      chk("idle_ready", in_ready, 1);

      vt.push_back('{C_ACC,   48'd8,               48'd0,    0, 48'd0,    8'd0, 0, 0});
      vt.push_back('{C_ACC,   48'hFFFF_FFFF_FFFE,  48'd0,    0, 48'd0,    8'd0, 0, 0});
      vt.push_back('{C_FLUSH, 48'd1028,            48'd1034, 1, 48'd1034, 8'd3, 0, 1});
      vt.push_back('{C_FLUSH, 48'd0,               48'd5,    1, 48'd0,    8'd1, 0, 0});
      vt.push_back('{C_ACC,   48'd5,               48'd0,    0, 48'd0,    8'd0, 0, 0});
      vt.push_back('{C_PASS,  48'd9,               48'd0,    1, 48'd9,    8'd1, 0, 0});
      vt.push_back('{C_FLUSH, 48'd1,               48'd0,    1, 48'd6,    8'd2, 0, 0});
      vt.push_back('{C_ACC,   48'h7FFF_FFFF_FFFF,  48'd0,    0, 48'd0,    8'd0, 0, 0});
      vt.push_back('{C_FLUSH, 48'd1,               48'd0,    1, 48'h8000_0000_0000, 8'd2, 1, 0});
      vt.push_back('{C_FLUSH, 48'd3,               48'd0,    1, 48'd3,    8'd1, 0, 0});
      vt.push_back('{C_ACC,   48'd10,              48'd0,    0, 48'd0,    8'd0, 0, 0});
      vt.push_back('{C_CLEAR, 48'd0,               48'd0,    0, 48'd0,    8'd0, 0, 0});
      vt.push_back('{C_FLUSH, 48'd2,               48'd0,    1, 48'd2,    8'd1, 0, 0});
      vt.push_back('{C_ACC,   48'h8000_0000_0000,  48'd0,    0, 48'd0,    8'd0, 0, 0});
      vt.push_back('{C_FLUSH, 48'hFFFF_FFFF_FFFF,  48'd0,    1, 48'h7FFF_FFFF_FFFF, 8'd2, 1, 0});
      vt.push_back('{C_PASS,  48'd42,              48'd42,   1, 48'd42,   8'd1, 0, 1});
      vt.push_back('{C_ACC,   48'h7FFF_FFFF_FFFF,  48'd0,    0, 48'd0,    8'd0, 0, 0});
      vt.push_back('{C_ACC,   48'd1,               48'd0,    0, 48'd0,    8'd0, 0, 0});
      vt.push_back('{C_ACC,   48'd2,               48'd0,    0, 48'd0,    8'd0, 0, 0});
      vt.push_back('{C_FLUSH, 48'd0,               48'd0,    1, 48'h8000_0000_0002, 8'd4, 1, 0});

      out_ready = 1'b1;
      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = vt[i].op; in_p = vt[i].p; pattern = vt[i].pat;
         tick();
         chk($sformatf("vec%0d_valid", i), out_valid, vt[i].ev);
         if (vt[i].ev) begin
            chk($sformatf("vec%0d_sum", i), out_sum, vt[i].es);
            chk($sformatf("vec%0d_count", i), out_count, vt[i].ec);
            chk($sformatf("vec%0d_ovf", i), out_ovf, vt[i].eo);
            chk($sformatf("vec%0d_hit", i), pat_hit, vt[i].eh);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      tick();

      // Back-pressure: first result must stall, then both drain in order.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_op = C_PASS; in_p = 48'd1;
      tick();
      chk("bp_first_valid", out_valid, 1);
      chk("bp_first_sum", out_sum, 1);
      chk("bp_ready_low", in_ready, 0);
      @(negedge clk);
      in_p = 48'd2;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("bp_hold_ready", in_ready, 0);
         chk("bp_hold_sum", out_sum, 1);
         chk("bp_hold_valid", out_valid, 1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      chk("bp_drain1_sum", out_sum, 1);
      tick();
      chk("bp_second_valid", out_valid, 1);
      chk("bp_second_sum", out_sum, 2);
      @(negedge clk);
      in_valid = 1'b0;
      tick();
      chk("bp_empty_valid", out_valid, 0);
      chk("bp_keep_sum", out_sum, 2);

      // Count saturation.
      @(negedge clk);
      in_valid = 1'b1; in_op = C_ACC; in_p = 48'd1;
      repeat (300) @(posedge clk);
      @(negedge clk);
      in_op = C_FLUSH; in_p = 48'd0; pattern = 48'd0;
      tick();
      chk("sat_sum", out_sum, 300);
      chk("sat_count", out_count, 255);
      @(negedge clk);
      in_valid = 1'b0;

      // Asynchronous reset discards partial sum and pending output.
      @(negedge clk);
      in_valid = 1'b1; in_op = C_ACC; in_p = 48'd7;
      @(negedge clk);
      @(negedge clk);
      out_ready = 1'b0; in_op = C_PASS; in_p = 48'd5;
      tick();
      chk("rstmid_pending", out_sum, 5);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_valid", out_valid, 0);
      chk("rstmid_sum", out_sum, 0);
      chk("rstmid_count", out_count, 0);
      chk("rstmid_flags", {out_ovf, pat_hit}, 0);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_op = C_FLUSH; in_p = 48'd4;
      tick();
      chk("rstmid_flush_sum", out_sum, 4);
      chk("rstmid_flush_count", out_count, 1);
      @(negedge clk);
      in_valid = 1'b0;
      tick();

      // Randomized run against the reference model.
      m_acc = 0; m_cnt = 0; m_ovf = 0;
      q.delete();
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 9))
            0, 1:    r_op = C_PASS;
            2, 3:    r_op = C_FLUSH;
            4:       r_op = C_CLEAR;
            default: r_op = C_ACC;
         endcase
         in_op     = r_op;
         in_p      = rnd_val();
         pattern   = 48'($urandom_range(0, 20));
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         exp_rdy = (q.size() == 0) || out_ready;
         chk("rnd_in_ready", in_ready, exp_rdy);
         chk("rnd_out_valid", out_valid, q.size() != 0);
         if (q.size() != 0 && out_ready) begin
            e = q.pop_front();
            chk("rnd_sum", out_sum, e.s);
            chk("rnd_count", out_count, e.c);
            chk("rnd_ovf", out_ovf, e.o);
            chk("rnd_hit", pat_hit, e.h);
         end
         if (in_valid && exp_rdy) model_op(in_op, in_p, pattern);
      end
      @(negedge clk);
      in_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
